// File: rtl/mac_result_drain.sv
// Drain for the integer MAC output: tracks last-term tags through the MAC latency,
// captures finished dot products into a FWFT FIFO, and issues credits so captures never overflow.
module mac_result_drain #(
    parameter int SUM_width     = 16,
    parameter int MULT_LATENCY  = 1,
    parameter int ADDER_LATENCY = 1,
    parameter int FIFO_DEPTH    = 4,
    parameter int CNT_width     = 9
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 issue_valid,
    input  logic                 issue_last,
    output logic                 issue_ready,
    input  logic [SUM_width-1:0] mac_z,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [SUM_width-1:0] out_data,
    output logic [CNT_width-1:0] fifo_count,
    output logic [CNT_width-1:0] credit_count
);
    localparam int L     = MULT_LATENCY + 1 + ADDER_LATENCY;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [CNT_width-1:0] DEPTH_C  = CNT_width'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0]     LAST_PTR = PTR_W'(FIFO_DEPTH - 1);

    logic [L-1:0]         tag_q, tag_d;
    logic [SUM_width-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CNT_width-1:0] count_q, count_d, credit_q, credit_d;
    logic                 issue_fire, take_credit, push, pop;

    always_comb begin
        issue_fire  = issue_valid & issue_ready;
        take_credit = issue_fire & issue_last;
        push        = tag_q[L-1];
        pop         = out_valid & out_ready;

        // Tags advance every cycle because the MAC pipeline never stalls.
        tag_d  = (tag_q << 1) | L'(take_credit);

        wptr_d = wptr_q;
        if (push) wptr_d = (wptr_q == LAST_PTR) ? '0 : wptr_q + PTR_W'(1);
        rptr_d = rptr_q;
        if (pop)  rptr_d = (rptr_q == LAST_PTR) ? '0 : rptr_q + PTR_W'(1);

        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_width'(1);
            2'b01:   count_d = count_q - CNT_width'(1);
            default: count_d = count_q;
        endcase

        credit_d = credit_q;
        case ({take_credit, pop})
            2'b10:   credit_d = credit_q - CNT_width'(1);
            2'b01:   credit_d = credit_q + CNT_width'(1);
            default: credit_d = credit_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_q    <= '0;
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            credit_q <= DEPTH_C;
        end else begin
            tag_q    <= tag_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            count_q  <= count_d;
            credit_q <= credit_d;
        end
    end

    // Storage holds data only; occupancy is tracked by count_q, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= mac_z;
    end

    assign issue_ready  = (credit_q != '0);
    assign out_valid    = (count_q != '0);
    assign out_data     = out_valid ? mem_q[rptr_q] : '0;
    assign fifo_count   = count_q;
    assign credit_count = credit_q;

    no_overflow_a: assert property (@(posedge clk) disable iff (rst) !(push && (count_q == DEPTH_C)));

endmodule
